clint: RTL and testbench
========================

CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL have parameter TickDiv, default 10, cycles per mtime increment when prescaler is compiled in (legal range 1..65535).
REQ-002 SHALL have parameter MsipReset, default 1'b0, reset value of msip bit.
REQ-003 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid_i  input  1  bus request valid.
REQ-006 SHALL have port req_ready_o  output  1  request accepted when valid&ready.
REQ-007 SHALL have port req_we_i  input  1  1=write, 0=read.
REQ-008 SHALL have port req_addr_i  input  16  byte offset, word aligned (bits [1:0] ignored).
REQ-009 SHALL have port req_wdata_i  input  32  write data, full-word only.
REQ-010 SHALL have port rsp_valid_o  output  1  response valid.
REQ-011 SHALL have port rsp_ready_i  input  1  response consumed when valid&ready.
REQ-012 SHALL have port rsp_rdata_o  output  32  read data (0 for writes).
REQ-013 SHALL have port msip_o  output  1  machine software interrupt pending, to CSR unit.
REQ-014 SHALL have port mtip_o  output  1  machine timer interrupt pending, to CSR unit.

Function
REQ-015 SHALL map registers: 0x0000 msip (bit 0 only), 0x4000 mtimecmp[31:0], 0x4004 mtimecmp[63:32], 0xBFF8 mtime[31:0], 0xBFFC mtime[63:32].
REQ-016 SHALL read unmapped offsets as 0 and ignore writes to them; msip bits [31:1] read 0.
REQ-017 SHALL support one outstanding transaction: req_ready_o = !rsp_valid_o || rsp_ready_i.
REQ-018 SHALL assert rsp_valid_o the cycle after acceptance, hold rsp_valid_o and rsp_rdata_o stable until rsp_ready_i; back-to-back accepts allowed when rsp_ready_i=1.
REQ-019 SHALL sample read data at acceptance cycle (value before any same-cycle increment).
REQ-020 SHALL commit writes at the acceptance edge; new value visible to reads accepted next cycle.
REQ-021 SHALL keep mtime as 64-bit counter, incrementing by 1 on each tick, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
REQ-022 SHALL on write to either mtime half replace only that half, suppress increment that cycle (write wins), and leave prescaler unchanged.
REQ-023 SHALL carry full 64 bits on increment (low half 0xFFFF_FFFF -> high half +1 same edge).
REQ-024 SHALL drive mtip_o from a register set to (mtime_q >= mtimecmp_q), unsigned 64-bit compare, i.e. one cycle after either operand changes.
REQ-025 SHALL drive msip_o directly from the msip register bit.
REQ-026 SHALL not latch mtip_o: lowering mtimecmp/raising it clears or sets mtip_o per REQ-024 only.

Reset
REQ-027 SHALL on rst_i=1 at edge set mtime=0, mtimecmp=all ones, msip=MsipReset, prescaler=0, rsp_valid_o=0, rsp_rdata_o=0, mtip_o=0.
REQ-028 SHALL drop any pending response on reset mid-transaction; no response for it after reset.
REQ-029 SHALL drive req_ready_o=1 in the first cycle after reset deasserts.

Configuration
REQ-030 SHALL, with CLINT_PRESCALER_EN defined, count prescaler 0..TickDiv-1 and tick mtime when prescaler wraps to 0.
REQ-031 SHALL, without CLINT_PRESCALER_EN, tick mtime every cycle and ignore TickDiv (no prescaler logic).

Verification
REQ-032 SHALL cover: reset, read 0x4000/0x4004 -> 0xFFFF_FFFF both; mtip_o=0, msip_o=0.
REQ-033 SHALL cover: write mtime lo=0xFFFF_FFFE hi=0, no prescaler -> after 2 ticks read hi=1, lo=0.
REQ-034 SHALL cover: mtimecmp=0x20 hi=0, mtime=0x10 -> mtip_o rises exactly one cycle after mtime reaches 0x20; write mtimecmp lo=0x1000 -> mtip_o falls next cycle.
REQ-035 SHALL cover: write 0x0000 data 0xFFFF_FFFF -> msip_o=1, read 0x0000 returns 0x1; write 0 -> msip_o=0.
REQ-036 SHALL cover: hold rsp_ready_i=0 for 3 cycles after read -> req_ready_o=0, rsp_rdata_o stable; CLINT_PRESCALER_EN with TickDiv=10 -> mtime +1 per 10 cycles.

Source files
------------

// File: rtl/clint.sv
// Core-local interruptor: msip, 64-bit mtime/mtimecmp and timer interrupt.
// Optional mtime prescaler is compiled in with CLINT_PRESCALER_EN.
module clint #(
    parameter int unsigned TickDiv   = 10,
    parameter logic        MsipReset = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [15:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        msip_o,
    output logic        mtip_o
);

    localparam logic [13:0] AddrMsip  = 14'h0000;
    localparam logic [13:0] AddrCmpLo = 14'h1000;
    localparam logic [13:0] AddrCmpHi = 14'h1001;
    localparam logic [13:0] AddrMtLo  = 14'h2FFE;
    localparam logic [13:0] AddrMtHi  = 14'h2FFF;

    logic        msip_q, msip_d;
    logic        mtip_q, mtip_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtcmp_q, mtcmp_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        accept;
    logic        wr;
    logic        tick;
    logic [13:0] word_addr;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
    logic [31:0] rd_mux;
    logic        unused_addr;

    assign word_addr   = req_addr_i[15:2];
    assign unused_addr = ^req_addr_i[1:0];

    assign req_ready_o = !rsp_valid_q || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign wr          = accept && req_we_i;

`ifdef CLINT_PRESCALER_EN
    localparam int unsigned PW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam logic [PW-1:0] PrescMax = PW'(TickDiv - 1);

    logic [PW-1:0] presc_q, presc_d;

    // mtime ticks on the cycle the prescaler wraps back to zero
    assign tick    = (presc_q == PrescMax);
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    logic unused_tickdiv;

    assign unused_tickdiv = ^TickDiv;
    assign tick           = 1'b1;
`endif

    always_comb begin
        sel_msip   = 1'b0;
        sel_cmp_lo = 1'b0;
        sel_cmp_hi = 1'b0;
        sel_mt_lo  = 1'b0;
        sel_mt_hi  = 1'b0;
        rd_mux     = '0;
        case (word_addr)
            AddrMsip: begin
                sel_msip = 1'b1;
                rd_mux   = {31'b0, msip_q};
            end
            AddrCmpLo: begin
                sel_cmp_lo = 1'b1;
                rd_mux     = mtcmp_q[31:0];
            end
            AddrCmpHi: begin
                sel_cmp_hi = 1'b1;
                rd_mux     = mtcmp_q[63:32];
            end
            AddrMtLo: begin
                sel_mt_lo = 1'b1;
                rd_mux    = mtime_q[31:0];
            end
            AddrMtHi: begin
                sel_mt_hi = 1'b1;
                rd_mux    = mtime_q[63:32];
            end
            default: ;
        endcase
    end

    // A write to either half wins over the increment in the same cycle
    always_comb begin
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr && sel_mt_lo) begin
            mtime_d = {mtime_q[63:32], req_wdata_i};
        end
        if (wr && sel_mt_hi) begin
            mtime_d = {req_wdata_i, mtime_q[31:0]};
        end
    end

    always_comb begin
        mtcmp_d = mtcmp_q;
        if (wr && sel_cmp_lo) begin
            mtcmp_d = {mtcmp_q[63:32], req_wdata_i};
        end
        if (wr && sel_cmp_hi) begin
            mtcmp_d = {req_wdata_i, mtcmp_q[31:0]};
        end
    end

    always_comb begin
        msip_d = msip_q;
        if (wr && sel_msip) begin
            msip_d = req_wdata_i[0];
        end
    end

    assign mtip_d = (mtime_q >= mtcmp_q);

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = req_we_i ? 32'h0 : rd_mux;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            msip_q      <= MsipReset;
            mtip_q      <= 1'b0;
            mtime_q     <= '0;
            mtcmp_q     <= '1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            msip_q      <= msip_d;
            mtip_q      <= mtip_d;
            mtime_q     <= mtime_d;
            mtcmp_q     <= mtcmp_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign msip_o      = msip_q;
    assign mtip_o      = mtip_q;

endmodule

// File: tb/tb_clint.sv
// Randomized bench for clint against an edge-indexed timeline model.
module tb_clint;

`ifdef CLINT_PRESCALER_EN
    localparam int TD = 10;
`else
    localparam int TD = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [15:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_rdata_o;
    logic        msip_o;
    logic        mtip_o;

    int total = 0;
    int bad = 0;
    int edge_n = 0;

    // timeline model: value after edge x derived from last write + tick count
    int          r_edge;
    logic [63:0] mt_v, mt_pv, cm_c, cm_p;
    int          mt_e, mt_pe, cm_e;
    logic        msip_m;

    clint #(.TickDiv(10), .MsipReset(1'b0)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o),
        .msip_o(msip_o), .mtip_o(mtip_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic [63:0] nticks(input int a, input int b);
        return 64'((b - r_edge) / TD - (a - r_edge) / TD);
    endfunction

    function automatic logic [63:0] mtime_at(input int x);
        if (x >= mt_e) return mt_v + nticks(mt_e, x);
        return mt_pv + nticks(mt_pe, x);
    endfunction

    function automatic logic [63:0] cmp_at(input int x);
        return (x >= cm_e) ? cm_c : cm_p;
    endfunction

    function automatic logic exp_mtip();
        return mtime_at(edge_n - 1) >= cmp_at(edge_n - 1);
    endfunction

    function automatic logic [31:0] exp_read(input logic [15:0] addr,
                                             input int a);
        logic [63:0] mt;
        logic [63:0] cm;
        mt = mtime_at(a - 1);
        cm = cmp_at(a - 1);
        case (addr & 16'hFFFC)
            16'h0000: return {31'b0, msip_m};
            16'h4000: return cm[31:0];
            16'h4004: return cm[63:32];
            16'hBFF8: return mt[31:0];
            16'hBFFC: return mt[63:32];
            default:  return 32'h0;
        endcase
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        req_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        r_edge = edge_n;
        rst_i = 1'b0;
        mt_v = '0; mt_pv = '0; mt_e = r_edge; mt_pe = r_edge;
        cm_c = '1; cm_p = '1; cm_e = r_edge;
        msip_m = 1'b0;
    endtask

    // Presents one request, waits for acceptance and updates the model.
    task automatic bus(input bit we, input logic [15:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output int a);
        bit got;
        logic [63:0] old;
        req_valid_i = 1'b1;
        req_we_i = we;
        req_addr_i = addr;
        req_wdata_i = wd;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            bit rdy;
            rdy = req_ready_o;
            @(posedge clk);
            #1;
            if (rdy) got = 1'b1;
        end
        req_valid_i = 1'b0;
        a = edge_n;
        rd = rsp_rdata_o;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL bus_accept addr=%h got=0 required=1", addr);
        end else if (we) begin
            old = mtime_at(a - 1);
            case (addr & 16'hFFFC)
                16'h0000: msip_m = wd[0];
                16'h4000: begin cm_p = cm_c; cm_c[31:0] = wd; cm_e = a; end
                16'h4004: begin cm_p = cm_c; cm_c[63:32] = wd; cm_e = a; end
                16'hBFF8: begin
                    mt_pv = mt_v; mt_pe = mt_e;
                    mt_v = {old[63:32], wd}; mt_e = a;
                end
                16'hBFFC: begin
                    mt_pv = mt_v; mt_pe = mt_e;
                    mt_v = {wd, old[31:0]}; mt_e = a;
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int a;
        rsp_ready_i = 1'b0;
        do_reset();
        total++;
        if (rsp_valid_o !== 1'b0) begin
            bad++; $display("FAIL rst_rsp_valid got=%b req=0", rsp_valid_o);
        end
        total++;
        if (rsp_rdata_o !== 32'h0) begin
            bad++; $display("FAIL rst_rdata got=%h req=0", rsp_rdata_o);
        end
        total++;
        if (req_ready_o !== 1'b1) begin
            bad++; $display("FAIL rst_ready got=%b req=1", req_ready_o);
        end
        total++;
        if (mtip_o !== 1'b0 || msip_o !== 1'b0) begin
            bad++; $display("FAIL rst_irq got=%b%b req=00", mtip_o, msip_o);
        end
        rsp_ready_i = 1'b1;
        bus(1'b0, 16'h4000, 32'h0, rd, a);
        total++;
        if (rd !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL rst_cmp_lo got=%h req=ffffffff", rd);
        end
        bus(1'b0, 16'h4004, 32'h0, rd, a);
        total++;
        if (rd !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL rst_cmp_hi got=%h req=ffffffff", rd);
        end
    endtask

    task automatic test_carry();
        logic [31:0] rd;
        logic [31:0] e;
        int a;
        bus(1'b1, 16'hBFFC, 32'h0, rd, a);
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFE, rd, a);
        repeat (25) @(posedge clk);
        #1;
        bus(1'b0, 16'hBFFC, 32'h0, rd, a);
        e = exp_read(16'hBFFC, a);
        total++;
        if (rd !== e || e !== 32'h1) begin
            bad++; $display("FAIL carry_hi got=%h req=%h", rd, e);
        end
        bus(1'b0, 16'hBFF8, 32'h0, rd, a);
        e = exp_read(16'hBFF8, a);
        total++;
        if (rd !== e) begin
            bad++; $display("FAIL carry_lo got=%h req=%h", rd, e);
        end
    endtask

    task automatic test_mtip();
        logic [31:0] rd;
        int a;
        int rise_e = -1;
        int reach_e = -1;
        bus(1'b1, 16'hBFFC, 32'h0, rd, a);
        bus(1'b1, 16'hBFF8, 32'h10, rd, a);
        bus(1'b1, 16'h4004, 32'h0, rd, a);
        bus(1'b1, 16'h4000, 32'h20, rd, a);
        for (int i = 0; i < 16 * TD + 20; i++) begin
            @(posedge clk);
            #1;
            if (reach_e < 0 && mtime_at(edge_n) >= 64'h20) reach_e = edge_n;
            if (rise_e < 0 && mtip_o === 1'b1) rise_e = edge_n;
            total++;
            if (mtip_o !== exp_mtip()) begin
                bad++;
                $display("FAIL mtip_track e=%0d got=%b req=%b",
                         edge_n, mtip_o, exp_mtip());
            end
        end
        total++;
        if (rise_e < 0 || rise_e != reach_e + 1) begin
            bad++;
            $display("FAIL mtip_rise got=%0d req=%0d", rise_e, reach_e + 1);
        end
        bus(1'b1, 16'h4000, 32'h1000, rd, a);
        total++;
        if (mtip_o !== 1'b1) begin
            bad++; $display("FAIL mtip_hold got=%b req=1", mtip_o);
        end
        @(posedge clk);
        #1;
        total++;
        if (mtip_o !== 1'b0) begin
            bad++; $display("FAIL mtip_fall got=%b req=0", mtip_o);
        end
    endtask

    task automatic test_msip();
        logic [31:0] rd;
        int a;
        bus(1'b1, 16'h0000, 32'hFFFF_FFFF, rd, a);
        total++;
        if (msip_o !== 1'b1) begin
            bad++; $display("FAIL msip_set got=%b req=1", msip_o);
        end
        bus(1'b0, 16'h0000, 32'h0, rd, a);
        total++;
        if (rd !== 32'h1) begin
            bad++; $display("FAIL msip_read got=%h req=1", rd);
        end
        bus(1'b0, 16'h0003, 32'h0, rd, a);
        total++;
        if (rd !== 32'h1) begin
            bad++; $display("FAIL msip_read_lowbits got=%h req=1", rd);
        end
        bus(1'b1, 16'h0000, 32'h0, rd, a);
        total++;
        if (msip_o !== 1'b0) begin
            bad++; $display("FAIL msip_clr got=%b req=0", msip_o);
        end
    endtask

    task automatic test_stall();
        logic [31:0] r0;
        logic [31:0] e;
        int a;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_we_i = 1'b0;
        req_addr_i = 16'hBFF8;
        @(posedge clk);
        #1;
        a = edge_n;
        e = exp_read(16'hBFF8, a);
        r0 = rsp_rdata_o;
        req_we_i = 1'b1;
        req_addr_i = 16'h0000;
        req_wdata_i = 32'h1;
        total++;
        if (r0 !== e || rsp_valid_o !== 1'b1) begin
            bad++; $display("FAIL stall_read got=%h req=%h", r0, e);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            total++;
            if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b1 ||
                rsp_rdata_o !== r0 || msip_o !== msip_m) begin
                bad++;
                $display("FAIL stall_hold got=%b%b %h %b req=01 %h %b",
                         req_ready_o, rsp_valid_o, rsp_rdata_o, msip_o,
                         r0, msip_m);
            end
        end
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        msip_m = 1'b1;
        total++;
        if (msip_o !== 1'b1 || rsp_valid_o !== 1'b1 || rsp_rdata_o !== 0) begin
            bad++;
            $display("FAIL stall_release got=%b%b %h req=11 0",
                     msip_o, rsp_valid_o, rsp_rdata_o);
        end
        @(posedge clk);
        #1;
        total++;
        if (rsp_valid_o !== 1'b0) begin
            bad++; $display("FAIL stall_drain got=%b req=0", rsp_valid_o);
        end
    endtask

    task automatic test_random();
        logic [15:0] addrs [9] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8,
                                   16'hBFFC, 16'h0004, 16'h8000, 16'h4008,
                                   16'hBFF4};
        logic [31:0] rd;
        logic [31:0] e;
        logic [31:0] wd;
        logic [15:0] ad;
        bit we;
        int a;
        int prev_a = -10;
        int gap = 1;
        for (int n = 0; n < 80; n++) begin
            ad = addrs[$urandom_range(0, 8)] | 16'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            if ((ad & 16'hFFFC) == 16'h4004 || (ad & 16'hFFFC) == 16'hBFFC)
                wd = 32'($urandom_range(0, 1));
            if ((ad & 16'hFFFC) == 16'h4000) wd = wd & 32'h3FF;
            e = we ? 32'h0 : exp_read(ad, edge_n + 1);
            bus(we, ad, wd, rd, a);
            if (!we) e = exp_read(ad, a);
            total++;
            if (rd !== e || rsp_valid_o !== 1'b1) begin
                bad++;
                $display("FAIL rand_rsp addr=%h we=%b got=%h req=%h",
                         ad, we, rd, e);
            end
            if (gap == 0) begin
                total++;
                if (a != prev_a + 1) begin
                    bad++;
                    $display("FAIL back_to_back got=%0d req=%0d", a, prev_a + 1);
                end
            end
            total++;
            if (mtip_o !== exp_mtip() || msip_o !== msip_m) begin
                bad++;
                $display("FAIL rand_irq got=%b%b req=%b%b",
                         mtip_o, msip_o, exp_mtip(), msip_m);
            end
            prev_a = a;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
                total++;
                if (mtip_o !== exp_mtip()) begin
                    bad++;
                    $display("FAIL rand_idle_mtip got=%b req=%b",
                             mtip_o, exp_mtip());
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_we_i = 1'b0;
        req_addr_i = 16'h4000;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        total++;
        if (rsp_valid_o !== 1'b1) begin
            bad++; $display("FAIL mid_pending got=%b req=1", rsp_valid_o);
        end
        do_reset();
        total++;
        if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 0 || req_ready_o !== 1) begin
            bad++;
            $display("FAIL mid_reset got=%b %h %b req=0 0 1",
                     rsp_valid_o, rsp_rdata_o, req_ready_o);
        end
        rsp_ready_i = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            total++;
            if (rsp_valid_o !== 1'b0) begin
                bad++; $display("FAIL mid_no_rsp got=%b req=0", rsp_valid_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_mtip();
        test_msip();
        test_stall();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
